fifo_v2: RTL and testbench

- Parametrised next-generation synchronous FIFO for the DMA datapath.
- Supports non-power-of-2 depths.
- Selectable read mode: show-ahead (first-word-fall-through) or standard 1-cycle read latency.
- Runtime-programmable almost-full/almost-empty thresholds; optional sticky overflow/underflow error flags.
- Sits between the DMA read/write engines and the host/memory interfaces wherever rate decoupling with backpressure is needed.

---
 rtl/fifo_v2.sv | 127 ++++++++++++
 tb/tb_fifo_v2.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_v2.sv
// rtl/fifo_v2.sv - parametrised synchronous FIFO, show-ahead or 1-cycle read, programmable thresholds.
// Optional sticky error flags enabled by defining FIFO_V2_ERR_FLAGS_EN.
module fifo_v2 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int FWFT  = 1,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  input  logic [CW-1:0]    af_thresh,
  input  logic [CW-1:0]    ae_thresh,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    space,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    next_count;
  logic             valid_wr;
  logic             valid_rd;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign valid_wr = wr_en && !full;
  assign valid_rd = rd_en && !empty;

  always_comb begin
    next_count = count;
    case ({valid_wr, valid_rd})
      2'b10:   next_count = count + 1'b1;
      2'b01:   next_count = count - 1'b1;
      default: next_count = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (valid_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      space        <= DEPTH_C;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
    end else begin
      if (valid_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (valid_rd) rd_ptr <= ptr_inc(rd_ptr);
      count        <= next_count;
      space        <= DEPTH_C - next_count;
      empty        <= (next_count == '0);
      full         <= (next_count == DEPTH_C);
      almost_empty <= (next_count <= ae_thresh);
      almost_full  <= (next_count >= af_thresh);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always visible; a write landing on rd_ptr shows up the next cycle.
      assign rd_data  = mem[rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_std
      logic [WIDTH-1:0] rd_q;
      logic             rd_valid_q;
      always_ff @(posedge clk) begin
        if (valid_rd) rd_q <= mem[rd_ptr];
      end
      always_ff @(posedge clk) begin
        if (rst) rd_valid_q <= 1'b0;
        else     rd_valid_q <= valid_rd;
      end
      assign rd_data  = rd_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

`ifdef FIFO_V2_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;
  // A read paired with a write on an empty FIFO is covered by the write, so it is not an underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_en && full)                 ovf_q <= 1'b1;
      else if (err_clr)                  ovf_q <= 1'b0;
      if (rd_en && empty && !wr_en)      unf_q <= 1'b1;
      else if (err_clr)                  unf_q <= 1'b0;
    end
  end
  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_v2.sv
// tb/tb_fifo_v2.sv - self-checking bench for fifo_v2 (DEPTH=5, show-ahead and standard read instances).
module tb_fifo_v2;

`ifdef FIFO_V2_ERR_FLAGS_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_en = 0, rd_en = 0, err_clr = 0;
  logic [W-1:0]  wr_data = '0, rd_data;
  logic          rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [CW-1:0] af_thresh = CW'(4), ae_thresh = CW'(1), count, space;

  logic          wr_en_b = 0, rd_en_b = 0, err_clr_b = 0;
  logic [W-1:0]  wr_data_b = '0, rd_data_b;
  logic          rd_valid_b, empty_b, full_b, ae_b, af_b, ovf_b, unf_b;
  logic [CW-1:0] count_b, space_b;

  fifo_v2 #(.WIDTH(W), .DEPTH(D), .FWFT(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .count(count), .space(space),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  fifo_v2 #(.WIDTH(W), .DEPTH(D), .FWFT(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b), .rd_en(rd_en_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .empty(empty_b), .full(full_b),
    .almost_empty(ae_b), .almost_full(af_b),
    .af_thresh(CW'(4)), .ae_thresh(CW'(1)), .count(count_b), .space(space_b),
    .overflow(ovf_b), .underflow(unf_b), .err_clr(err_clr_b)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] sbq[$];
  logic [W-1:0] sbq_b[$];
  int mcount = 0;

  typedef struct {
    logic       wr, rd, clr;
    logic [7:0] din;
    int         cnt;
    logic       e, f, af, ae, ovf, unf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive one cycle on dut_a, score any show-ahead word consumed.
  task automatic cyc_a(input logic w, input logic r, input logic c, input logic [7:0] d);
    wr_en = w; rd_en = r; err_clr = c; wr_data = d;
    if (r && mcount > 0) begin
      chk("fwft_rd_data", rd_data, sbq[0]);
      void'(sbq.pop_front());
    end
    if (w && mcount < D) sbq.push_back(d);
    mcount = mcount + ((w && mcount < D) ? 1 : 0) - ((r && mcount > 0) ? 1 : 0);
    @(posedge clk);
    @(negedge clk);
    wr_en = 0; rd_en = 0; err_clr = 0;
  endtask

  vec_t tbl[$];

  initial begin
    tbl = '{
      '{1,0,0,8'h11,1,0,0,0,1,0,0},
      '{1,0,0,8'h12,2,0,0,0,0,0,0},
      '{1,0,0,8'h13,3,0,0,0,0,0,0},
      '{1,0,0,8'h14,4,0,0,1,0,0,0},
      '{1,0,0,8'h15,5,0,1,1,0,0,0},
      '{1,0,0,8'h16,5,0,1,1,0,1,0},
      '{0,1,0,8'h00,4,0,0,1,0,1,0},
      '{0,1,0,8'h00,3,0,0,0,0,1,0},
      '{0,1,0,8'h00,2,0,0,0,0,1,0},
      '{0,1,0,8'h00,1,0,0,0,1,1,0},
      '{0,1,0,8'h00,0,1,0,0,1,1,0},
      '{0,1,0,8'h00,0,1,0,0,1,1,1},
      '{0,0,1,8'h00,0,1,0,0,1,0,0},
      '{1,1,0,8'h21,1,0,0,0,1,0,0},
      '{1,0,0,8'h22,2,0,0,0,0,0,0},
      '{1,1,0,8'h23,2,0,0,0,0,0,0},
      '{0,1,0,8'h00,1,0,0,0,1,0,0},
      '{0,1,0,8'h00,0,1,0,0,1,0,0}
    };

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_count", count, 0);
    chk("rst_space", space, D);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_b_rd_valid", rd_valid_b, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc_a(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
      chk($sformatf("v%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("v%0d_space", i), space, D - tbl[i].cnt);
      chk($sformatf("v%0d_empty", i), empty, tbl[i].e);
      chk($sformatf("v%0d_rd_valid", i), rd_valid, !tbl[i].e);
      chk($sformatf("v%0d_full", i), full, tbl[i].f);
      chk($sformatf("v%0d_af", i), almost_full, tbl[i].af);
      chk($sformatf("v%0d_ae", i), almost_empty, tbl[i].ae);
      chk($sformatf("v%0d_ovf", i), overflow, ERR & tbl[i].ovf);
      chk($sformatf("v%0d_unf", i), underflow, ERR & tbl[i].unf);
    end

    // Pointer wrap with steady occupancy of 3.
    for (int i = 0; i < 3; i++) cyc_a(1, 0, 0, 8'h30 + 8'(i));
    for (int i = 0; i < 12; i++) begin
      cyc_a(1, 1, 0, 8'h40 + 8'(i));
      chk("wrap_count", count, 3);
      chk("wrap_sum", 32'(count) + 32'(space), D);
    end
    chk("wrap_sb_depth", sbq.size(), 3);

    // Reset in the middle of traffic.
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    sbq.delete();
    mcount = 0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_space", space, D);

    // Threshold change takes effect with no traffic.
    for (int i = 0; i < 3; i++) cyc_a(1, 0, 0, 8'h50 + 8'(i));
    chk("thr_af_before", almost_full, 0);
    af_thresh = CW'(2);
    cyc_a(0, 0, 0, 8'h00);
    chk("thr_af_after", almost_full, 1);
    chk("thr_count", count, 3);
    cyc_a(0, 1, 0, 8'h00);
    chk("thr_after_pop", count, 2);

    // Standard-read instance.
    wr_en_b = 1; wr_data_b = 8'hA5; sbq_b.push_back(8'hA5);
    @(posedge clk); @(negedge clk);
    wr_en_b = 0; rd_en_b = 1;
    chk("std_rd_valid_before", rd_valid_b, 0);
    @(posedge clk); @(negedge clk);
    rd_en_b = 0;
    chk("std_rd_valid", rd_valid_b, 1);
    chk("std_rd_data", rd_data_b, sbq_b[0]);
    void'(sbq_b.pop_front());
    chk("std_empty", empty_b, 1);
    @(posedge clk); @(negedge clk);
    chk("std_rd_valid_one_cycle", rd_valid_b, 0);
    chk("std_rd_data_hold", rd_data_b, 8'hA5);
    rd_en_b = 1;
    @(posedge clk); @(negedge clk);
    rd_en_b = 0;
    chk("std_rd_empty_valid", rd_valid_b, 0);
    chk("std_unf", unf_b, ERR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
